// File: rtl/vga_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : vga_pkg
// Brief   : Shared constants and types for the VGA framebuffer writer.
//           It holds the SFR select codes, the CTRL bit positions, the
//           framebuffer geometry defaults and the writer state type.
// Revision: 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Framebuffer geometry defaults: 80x60 pixels, 13-bit video RAM address
    localparam int FB_PIXELS_DEF = 4800;
    localparam int ADDR_W_DEF    = 13;

    // SFR register select codes
    localparam logic [1:0] SEL_ADDR_LO = 2'd0;
    localparam logic [1:0] SEL_ADDR_HI = 2'd1;
    localparam logic [1:0] SEL_DATA    = 2'd2;
    localparam logic [1:0] SEL_CTRL    = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_ABORT_BIT = 1;

    // Writer state: byte phase (IDLE/HALF) or hardware fill
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        FILL = 2'd2
    } fb_state_t;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_fb_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : vga_fb_writer
// Brief   : CPU-side framebuffer writer. It assembles byte-wide SFR writes
//           into RGB565 pixels and writes them to video RAM at an
//           auto-incrementing pointer. It can also fill the whole
//           framebuffer with the last assembled colour, reporting busy and
//           done status.
// Revision: 1.0 - initial release
// ============================================================================
module vga_fb_writer
    import vga_pkg::*;
#(
    parameter int FB_PIXELS = FB_PIXELS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [1:0]        i_sfr_sel,
    input  logic [7:0]        i_wr_data,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [15:0]       o_ram_data,
    output logic              o_ram_we,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_half
);

    // Framebuffer bounds in address width. The fill counter runs up to
    // c_fb_size, so FB_PIXELS must stay below 2**ADDR_W.
    localparam logic [ADDR_W-1:0] c_fb_size = ADDR_W'(FB_PIXELS);
    localparam logic [ADDR_W-1:0] c_fb_last = ADDR_W'(FB_PIXELS - 1);

    fb_state_t         r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_fill_addr;
    logic [15:0]       r_fill_color;
    logic [7:0]        r_low_byte;

    logic              w_wr_lo;
    logic              w_wr_hi;
    logic              w_wr_data;
    logic              w_start;
    logic              w_abort;
    logic [ADDR_W-1:0] w_lo_ptr;
    logic [ADDR_W-1:0] w_hi_ptr;
    logic [ADDR_W-1:0] w_lo_ptr_ok;
    logic [ADDR_W-1:0] w_hi_ptr_ok;
    logic [ADDR_W-1:0] w_ptr_inc;
    logic [15:0]       w_pixel;

    // Decode the SFR write strobe into per-register events
    assign w_wr_lo   = i_wr_en && (i_sfr_sel == SEL_ADDR_LO);
    assign w_wr_hi   = i_wr_en && (i_sfr_sel == SEL_ADDR_HI);
    assign w_wr_data = i_wr_en && (i_sfr_sel == SEL_DATA);
    assign w_abort   = i_wr_en && (i_sfr_sel == SEL_CTRL) && i_wr_data[CTRL_ABORT_BIT];
    // Abort takes priority, so a write with both bits set never starts a fill
    assign w_start   = i_wr_en && (i_sfr_sel == SEL_CTRL) && i_wr_data[CTRL_START_BIT]
                       && !i_wr_data[CTRL_ABORT_BIT];

    // Candidate pointers for an ADDR_LO / ADDR_HI load, keeping the other half
    assign w_lo_ptr = {r_ptr[ADDR_W-1:8], i_wr_data};
    assign w_hi_ptr = {i_wr_data[ADDR_W-9:0], r_ptr[7:0]};

    // Out-of-range loads snap the pointer back to the first pixel
    assign w_lo_ptr_ok = (w_lo_ptr >= c_fb_size) ? '0 : w_lo_ptr;
    assign w_hi_ptr_ok = (w_hi_ptr >= c_fb_size) ? '0 : w_hi_ptr;

    // Post-write pointer wraps from the last pixel to the first
    assign w_ptr_inc = (r_ptr == c_fb_last) ? '0 : r_ptr + 1'b1;

    // High byte arrives second, so it forms the upper half of the pixel
    assign w_pixel = {i_wr_data, r_low_byte};

    // Pointer, byte phase, fill sequencer and all registered outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_fill_addr  <= '0;
            r_fill_color <= 16'h0000;
            r_low_byte   <= 8'h00;
            o_ram_addr   <= '0;
            o_ram_data   <= 16'h0000;
            o_ram_we     <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_half       <= 1'b0;
        end else begin
            // Write enable and done are single-cycle pulses by default
            o_ram_we <= 1'b0;
            o_done   <= 1'b0;

            case (r_state)
                FILL: begin
                    // SFR address/data writes are dropped while filling
                    if (w_abort) begin
                        // Abort leaves the pointer where the CPU last put it
                        r_state <= IDLE;
                        o_busy  <= 1'b0;
                    end else if (r_fill_addr == c_fb_size) begin
                        // Last pixel went out in the previous cycle
                        r_state <= IDLE;
                        r_ptr   <= '0;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                    end else begin
                        o_ram_we    <= 1'b1;
                        o_ram_addr  <= r_fill_addr;
                        o_ram_data  <= r_fill_color;
                        r_fill_addr <= r_fill_addr + 1'b1;
                    end
                end

                default: begin
                    if (w_wr_lo) begin
                        r_ptr   <= w_lo_ptr_ok;
                        r_state <= IDLE;
                        o_half  <= 1'b0;
                    end else if (w_wr_hi) begin
                        r_ptr   <= w_hi_ptr_ok;
                        r_state <= IDLE;
                        o_half  <= 1'b0;
                    end else if (w_wr_data) begin
                        if (r_state == HALF) begin
                            o_ram_we     <= 1'b1;
                            o_ram_addr   <= r_ptr;
                            o_ram_data   <= w_pixel;
                            r_fill_color <= w_pixel;
                            r_ptr        <= w_ptr_inc;
                            r_state      <= IDLE;
                            o_half       <= 1'b0;
                        end else begin
                            r_low_byte <= i_wr_data;
                            r_state    <= HALF;
                            o_half     <= 1'b1;
                        end
                    end else if (w_start) begin
                        // First fill write goes out together with busy; any
                        // pending low byte is discarded
                        r_state     <= FILL;
                        o_busy      <= 1'b1;
                        o_half      <= 1'b0;
                        o_ram_we    <= 1'b1;
                        o_ram_addr  <= '0;
                        o_ram_data  <= r_fill_color;
                        r_fill_addr <= ADDR_W'(1);
                    end
                end
            endcase
        end
    end

endmodule : vga_fb_writer
`default_nettype wire
